// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if -- request/result bundle between the EX stage and the
// iterative multiply/divide unit.
//
// Signals (directions seen from the unit, i.e. the slave modport):
//   start   in   EX-stage request, qualified by op
//   op      in   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved
//   rs, rt  in   operands (rs: dividend/multiplicand/MT source, rt: divisor/multiplier)
//   rd_req  in   MFHI/MFLO in EX this cycle
//   busy    out  iterative operation in progress
//   stall   out  pipeline must hold EX
//   done    out  one-cycle pulse, HI/LO just updated by a mul/div
//   HI, LO  out  architectural HI/LO registers
interface muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs;
    logic [XLEN-1:0] rt;
    logic            rd_req;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] HI;
    logic [XLEN-1:0] LO;

    modport master (
        output start, op, rs, rt, rd_req,
        input  busy, stall, done, HI, LO
    );

    modport slave (
        input  start, op, rs, rt, rd_req,
        output busy, stall, done, HI, LO
    );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq -- sequential MIPS-style multiply/divide unit owning HI/LO.
//
// Multiplies use one shift-add step per cycle, divides one restoring
// shift-subtract step per cycle, both on magnitudes; signs are applied in
// a final FIX cycle. MTHI/MTLO write HI/LO directly without going busy.
//
// Ports:
//   CLK    in   single clock, rising edge
//   RST_N  in   asynchronous active-low reset
//   bus    slave side of muldiv_seq_if (start/op/rs/rt/rd_req in,
//          busy/stall/done/HI/LO out)
//
// Configuration macro:
//   MULDIV_DIV0_FAST_EN  when defined, DIV/DIVU with rt=0 skip the 32
//                        iterations and go straight to FIX.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic        CLK,
    input  logic        RST_N,
    muldiv_seq_if.slave bus
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [5:0] LAST_CNT = 6'(XLEN - 1);

    state_t            state;
    state_t            next_state;
    logic [5:0]        cnt;
    logic [XLEN-1:0]   opa;
    logic [XLEN-1:0]   opb;
    logic [2*XLEN-1:0] prod;
    logic              rs_neg;
    logic              neg_res;
    logic              div0;
    logic              is_div;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic              done_q;

    logic              accept;
    logic              accept_iter;
    logic              op_is_div;
    logic              op_signed;
    logic [XLEN-1:0]   abs_rs;
    logic [XLEN-1:0]   abs_rt;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem;

    assign accept      = bus.start && (state == IDLE) && (bus.op <= OP_MTLO);
    assign accept_iter = accept && (bus.op <= OP_DIVU);
    assign op_is_div   = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    assign op_signed   = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign abs_rs      = (op_signed && bus.rs[XLEN-1]) ? -bus.rs : bus.rs;
    assign abs_rt      = (op_signed && bus.rt[XLEN-1]) ? -bus.rt : bus.rt;

    // Multiply: prod holds {partial product, remaining multiplier bits};
    // add the multiplicand into the top half when the multiplier LSB is set,
    // then shift everything right by one.
    assign mul_sum = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opa} : '0);

    // Divide: prod holds {remainder, remaining dividend / quotient bits};
    // shift left by one and subtract the divisor if it fits.
    assign div_shift = prod[2*XLEN-1:XLEN-1];
    assign div_ge    = div_shift >= {1'b0, opb};
    assign div_rem   = div_ge ? (div_shift[XLEN-1:0] - opb) : div_shift[XLEN-1:0];

    assign bus.busy  = (state != IDLE);
    assign bus.stall = bus.busy & (bus.start | bus.rd_req);
    assign bus.done  = done_q;
    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A zero divisor can bypass the iterations entirely
    // when the fast path is built in; its result does not depend on them.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept_iter) begin
                    if (op_is_div) begin
`ifdef MULDIV_DIV0_FAST_EN
                        next_state = (bus.rt == '0) ? FIX : DIV;
`else
                        next_state = DIV;
`endif
                    end else begin
                        next_state = MUL;
                    end
                end
            end
            MUL:     if (cnt == LAST_CNT) next_state = FIX;
            DIV:     if (cnt == LAST_CNT) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration steps and the final HI/LO write.
    // For a zero divisor HI gets rs back by re-applying its sign to |rs|,
    // which also works on the fast path where prod was never iterated.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt     <= '0;
            opa     <= '0;
            opb     <= '0;
            prod    <= '0;
            rs_neg  <= 1'b0;
            neg_res <= 1'b0;
            div0    <= 1'b0;
            is_div  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state == FIX);
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bus.op == OP_MTHI) begin
                            hi_q <= bus.rs;
                        end else if (bus.op == OP_MTLO) begin
                            lo_q <= bus.rs;
                        end else begin
                            opa     <= abs_rs;
                            opb     <= abs_rt;
                            prod    <= op_is_div ? {{XLEN{1'b0}}, abs_rs} : {{XLEN{1'b0}}, abs_rt};
                            rs_neg  <= op_signed && bus.rs[XLEN-1];
                            neg_res <= op_signed && (bus.rs[XLEN-1] ^ bus.rt[XLEN-1]);
                            div0    <= op_is_div && (bus.rt == '0);
                            is_div  <= op_is_div;
                            cnt     <= '0;
                        end
                    end
                end
                MUL: begin
                    prod <= {mul_sum, prod[XLEN-1:1]};
                    cnt  <= cnt + 6'd1;
                end
                DIV: begin
                    prod <= {div_rem, prod[XLEN-2:0], div_ge};
                    cnt  <= cnt + 6'd1;
                end
                FIX: begin
                    if (div0) begin
                        lo_q <= '1;
                        hi_q <= rs_neg ? -opa : opa;
                    end else if (is_div) begin
                        lo_q <= neg_res ? -prod[XLEN-1:0] : prod[XLEN-1:0];
                        hi_q <= rs_neg ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
                    end else begin
                        {hi_q, lo_q} <= neg_res ? -prod : prod;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq -- self-checking bench for muldiv_seq. Drives inputs on the
// falling edge, samples outputs on the falling edge, and compares against a
// plain-arithmetic reference model of HI/LO.
module tb_muldiv_seq;

    logic CLK = 1'b0;
    logic RST_N;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    muldiv_seq_if #(.XLEN(32)) bus ();

    muldiv_seq #(.XLEN(32)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Architectural result of one operation on HI/LO.
    function automatic void ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                      inout logic [31:0] hi, inout logic [31:0] lo);
        longint sa, sb, p;
        logic [63:0] u;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            3'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            3'd1: begin u = {32'b0, a} * {32'b0, b}; hi = u[63:32]; lo = u[31:0]; end
            3'd2: begin
                if (b == 0) begin lo = '1; hi = a; end
                else begin p = sa / sb; lo = p[31:0]; p = sa % sb; hi = p[31:0]; end
            end
            3'd3: begin
                if (b == 0) begin lo = '1; hi = a; end
                else begin lo = a / b; hi = a % b; end
            end
            3'd4: hi = a;
            3'd5: lo = a;
            default: ;
        endcase
    endfunction

    function automatic int exp_busy(input logic [2:0] op, input logic [31:0] b);
`ifdef MULDIV_DIV0_FAST_EN
        if ((op == 3'd2 || op == 3'd3) && b == 0) return 1;
`endif
        return 33;
    endfunction

    // Called at a falling edge: presents one request, then follows busy until
    // it drops (bounded), recording busy length, done pulse shape and HI/LO
    // in the done cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int bcnt, output logic done_ok, output logic early,
                          output logic [31:0] hi_d, output logic [31:0] lo_d);
        bus.start = 1'b1; bus.op = op; bus.rs = a; bus.rt = b;
        @(negedge CLK);
        bus.start = 1'b0;
        bcnt = 0;
        early = 1'b0;
        while (bus.busy === 1'b1 && bcnt < 100) begin
            if (bus.done !== 1'b0) early = 1'b1;
            bcnt++;
            @(negedge CLK);
        end
        done_ok = (bus.done === 1'b1);
        hi_d = bus.HI;
        lo_d = bus.LO;
        @(negedge CLK);
        if (bus.done !== 1'b0) done_ok = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        bus.start = 1'b0; bus.op = '0; bus.rs = '0; bus.rt = '0; bus.rd_req = 1'b0;
        repeat (3) @(negedge CLK);
        n_checks++;
        if ({bus.HI, bus.LO} !== 64'h0) $display("[TB] FAIL reset_hilo: got %h_%h expected 0_0", bus.HI, bus.LO);
        else n_pass++;
        n_checks++;
        if ({bus.busy, bus.done, bus.stall} !== 3'b000)
            $display("[TB] FAIL reset_flags: busy/done/stall got %b expected 000", {bus.busy, bus.done, bus.stall});
        else n_pass++;
        RST_N = 1'b1;
        @(negedge CLK);
        exp_hi = '0;
        exp_lo = '0;
    endtask

    task automatic test_directed();
        logic [2:0]  ops [6] = '{3'd1, 3'd0, 3'd2, 3'd2, 3'd3, 3'd2};
        logic [31:0] as  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'h80000000, 32'd100, 32'hFFFFFFFB};
        logic [31:0] bs  [6] = '{32'hFFFFFFFF, 32'd7, 32'd2, 32'hFFFFFFFF, 32'd0, 32'd0};
        logic [31:0] his [6] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'd100, 32'hFFFFFFFB};
        logic [31:0] los [6] = '{32'h00000001, 32'hFFFFFFEB, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        int bcnt; logic dok, early; logic [31:0] hd, ld;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], as[i], bs[i], bcnt, dok, early, hd, ld);
            n_checks++;
            if ({hd, ld} !== {his[i], los[i]})
                $display("[TB] FAIL directed_%0d_hilo: got %h_%h expected %h_%h", i, hd, ld, his[i], los[i]);
            else n_pass++;
            n_checks++;
            if (bcnt != exp_busy(ops[i], bs[i]) || !dok || early)
                $display("[TB] FAIL directed_%0d_timing: busy %0d cycles done_ok %b early %b, expected busy %0d done_ok 1 early 0",
                         i, bcnt, dok, early, exp_busy(ops[i], bs[i]));
            else n_pass++;
            exp_hi = his[i];
            exp_lo = los[i];
        end
    endtask

    task automatic test_random();
        logic [2:0] op; logic [31:0] a, b;
        int bcnt; logic dok, early; logic [31:0] hd, ld;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = 32'($urandom_range(1, 15));
                2: a = 32'h80000000;
                3: b = 32'hFFFFFFFF;
                default: ;
            endcase
            ref_model(op, a, b, exp_hi, exp_lo);
            if (op <= 3'd3) begin
                run_op(op, a, b, bcnt, dok, early, hd, ld);
                n_checks++;
                if ({hd, ld} !== {exp_hi, exp_lo} || bcnt != exp_busy(op, b) || !dok || early)
                    $display("[TB] FAIL random_%0d op%0d %h,%h: hilo %h_%h busy %0d done_ok %b early %b, expected %h_%h busy %0d 1 0",
                             i, op, a, b, hd, ld, bcnt, dok, early, exp_hi, exp_lo, exp_busy(op, b));
                else n_pass++;
            end else begin
                bus.start = 1'b1; bus.op = op; bus.rs = a; bus.rt = b;
                @(negedge CLK);
                bus.start = 1'b0;
                n_checks++;
                if ({bus.HI, bus.LO} !== {exp_hi, exp_lo} || bus.busy !== 1'b0 || bus.done !== 1'b0)
                    $display("[TB] FAIL random_%0d op%0d: hilo %h_%h busy %b done %b, expected %h_%h 0 0",
                             i, op, bus.HI, bus.LO, bus.busy, bus.done, exp_hi, exp_lo);
                else n_pass++;
                @(negedge CLK);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] a = 32'h12345678;
        logic [31:0] b = 32'h9ABCDEF0;
        int stall_bad = 0;
        logic exp_stall;
        ref_model(3'd1, a, b, exp_hi, exp_lo);
        bus.start = 1'b1; bus.op = 3'd1; bus.rs = a; bus.rt = b;
        @(negedge CLK);
        for (int cyc = 1; cyc <= 33; cyc++) begin
            if (cyc == 5) bus.rd_req = 1'b1;
            if (cyc >= 8 && cyc <= 10) begin
                bus.start = 1'b1; bus.op = 3'd3; bus.rs = 32'd1000; bus.rt = 32'd7;
            end else begin
                bus.start = 1'b0;
            end
            exp_stall = (cyc >= 5) || (cyc >= 8 && cyc <= 10);
            #1;
            if (bus.stall !== exp_stall || bus.busy !== 1'b1) stall_bad++;
            @(negedge CLK);
        end
        n_checks++;
        if (stall_bad != 0) $display("[TB] FAIL stall_during_busy: %0d bad cycles expected 0", stall_bad);
        else n_pass++;
        n_checks++;
        if ({bus.busy, bus.done, bus.stall} !== 3'b010)
            $display("[TB] FAIL stall_done_cycle: busy/done/stall got %b expected 010", {bus.busy, bus.done, bus.stall});
        else n_pass++;
        n_checks++;
        if ({bus.HI, bus.LO} !== {exp_hi, exp_lo})
            $display("[TB] FAIL stall_first_op_only: got %h_%h expected %h_%h", bus.HI, bus.LO, exp_hi, exp_lo);
        else n_pass++;
        bus.rd_req = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        int bcnt; logic dok, early; logic [31:0] hd, ld;
        bus.start = 1'b1; bus.op = 3'd5; bus.rs = 32'h1234;
        @(negedge CLK);
        bus.start = 1'b0;
        exp_lo = 32'h1234;
        n_checks++;
        if (bus.LO !== 32'h1234 || bus.busy !== 1'b0)
            $display("[TB] FAIL mtlo: LO %h busy %b expected 00001234 0", bus.LO, bus.busy);
        else n_pass++;
        bus.start = 1'b1; bus.op = 3'd2; bus.rs = 32'd5000; bus.rt = 32'd3;
        @(negedge CLK);
        bus.start = 1'b0;
        repeat (9) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        n_checks++;
        if ({bus.HI, bus.LO} !== 64'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("[TB] FAIL reset_mid_async: hilo %h_%h busy %b done %b expected 0_0 0 0", bus.HI, bus.LO, bus.busy, bus.done);
        else n_pass++;
        @(negedge CLK);
        RST_N = 1'b1;
        exp_hi = '0;
        exp_lo = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || {bus.HI, bus.LO} !== 64'h0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("[TB] FAIL reset_mid_abandon: %0d bad cycles expected 0", bad);
        else n_pass++;
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        ref_model(3'd3, 32'd77, 32'd5, exp_hi, exp_lo);
        run_op(3'd3, 32'd77, 32'd5, bcnt, dok, early, hd, ld);
        n_checks++;
        if ({hd, ld} !== {exp_hi, exp_lo} || bcnt != 33 || !dok)
            $display("[TB] FAIL reset_first_start: hilo %h_%h busy %0d done_ok %b expected %h_%h 33 1",
                     hd, ld, bcnt, dok, exp_hi, exp_lo);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
